signed_step_counter: RTL and testbench

- Upstream input stage for the two-digit seven-segment display driver.
- Turns two push buttons (up, down) and a clear button into a 4-bit two's-complement value on `data`.
- The display driver renders that value, so the count is held within the displayable range -4..+3.
- Per-button logic: 2-flop synchroniser, debounce filter, rising-edge one-shot. Saturating signed up/down counter follows.

---
 rtl/signed_step_counter_if.sv | 22 ++
 rtl/signed_step_counter.sv | 86 ++++++++
 tb/tb_signed_step_counter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/signed_step_counter_if.sv
// Button and display-value bundle between the button front end and its user.
// Buttons are raw asynchronous levels; data is the two's-complement count.
interface signed_step_counter_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_clr;
  logic [3:0] data;
  logic       at_max;
  logic       at_min;

  // Side that presses the buttons and watches the count.
  modport master (
    output btn_up, btn_dn, btn_clr,
    input  data, at_max, at_min
  );

  // Counter side: takes the buttons, produces the count.
  modport slave (
    input  btn_up, btn_dn, btn_clr,
    output data, at_max, at_min
  );
endinterface

// File: rtl/signed_step_counter.sv
// Three push buttons (up, down, clear) -> saturating signed 4-bit count.
// Each button path: 2-flop synchroniser, debounce filter, rising-edge one-shot.
// Bit order of the per-button vectors: [0] up, [1] down, [2] clear.
module signed_step_counter #(
  parameter int unsigned       DEBOUNCE_CNT = 65000,
  parameter logic signed [3:0] MIN_VAL      = -4,
  parameter logic signed [3:0] MAX_VAL      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  signed_step_counter_if.slave  bus
);

  // The filter flips on the cycle the counter already shows DEBOUNCE_CNT-1
  // differing cycles, i.e. on the DEBOUNCE_CNT-th consecutive one.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CNT - 1);

  logic [2:0]        raw;
  logic [2:0]        meta;
  logic [2:0]        sync;
  logic [2:0]        stable;
  logic [2:0]        prev;
  logic [2:0]        pulse;
  logic [15:0]       db_cnt [3];
  logic signed [3:0] data;

  assign raw = {bus.btn_clr, bus.btn_dn, bus.btn_up};

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Debounce: any agreeing cycle restarts the run, so short glitches never flip stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Edge history for the one-shot; a held button yields a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= stable;
  end

  assign pulse = stable & ~prev;

  // Count update: clear wins, up+down together cancel, otherwise saturate at the bounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (pulse[2]) begin
      data <= '0;
    end else if (pulse[0] && pulse[1]) begin
      data <= data;
    end else if (pulse[0]) begin
      if (data < MAX_VAL) data <= data + 4'sd1;
    end else if (pulse[1]) begin
      if (data > MIN_VAL) data <= data - 4'sd1;
    end
  end

  assign bus.data   = data;
  assign bus.at_max = (data == MAX_VAL);
  assign bus.at_min = (data == MIN_VAL);

endmodule

// File: tb/tb_signed_step_counter.sv
// Directed bench for signed_step_counter with DEBOUNCE_CNT = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// A raw press first sampled on rising edge 1 moves data on rising edge 7.
module tb_signed_step_counter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic range_bad = 1'b0;

  always #5 clk = ~clk;

  signed_step_counter_if bus ();

  signed_step_counter #(
    .DEBOUNCE_CNT (4),
    .MIN_VAL      (-4),
    .MAX_VAL      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Catch any out-of-range value (wrap) at any sample point.
  always @(negedge clk) begin
    if (!rst && (($signed(bus.data) > 4'sd3) || ($signed(bus.data) < -4'sd4)))
      range_bad = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input int observed, input int expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int dval();
    logic signed [3:0] v;
    v = bus.data;
    return int'(v);
  endfunction

  task automatic set_btns(input logic u, input logic d, input logic c);
    bus.btn_up  = u;
    bus.btn_dn  = d;
    bus.btn_clr = c;
  endtask

  // Clean press: hold for 10 cycles, then release and let everything settle.
  task automatic press(input logic u, input logic d, input logic c);
    set_btns(u, d, c);
    tick(10);
    set_btns(1'b0, 1'b0, 1'b0);
    tick(12);
  endtask

  int exp_up_d [5]  = '{1, 2, 3, 3, 3};
  int exp_up_mx[5]  = '{0, 0, 1, 1, 1};
  int exp_dn_d [8]  = '{2, 1, 0, -1, -2, -3, -4, -4};
  int exp_dn_mn[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    set_btns(1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset state
    tick(3);
    check_eq("rst_data", dval(), 0);
    check_eq("rst_at_max", int'(bus.at_max), 0);
    check_eq("rst_at_min", int'(bus.at_min), 0);
    rst = 1'b0;
    tick(20);
    check_eq("idle_data", dval(), 0);

    // Single press: exact latency, one increment, no change on release
    bus.btn_up = 1'b1;
    tick(6);
    check_eq("lat_edge6", dval(), 0);
    tick(1);
    check_eq("lat_edge7", dval(), 1);
    tick(3);
    bus.btn_up = 1'b0;
    tick(12);
    check_eq("single_inc", dval(), 1);

    // Clear back to zero
    press(1'b0, 1'b0, 1'b1);
    check_eq("clr_to_0", dval(), 0);

    // Saturation upward
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 1'b0);
      check_eq($sformatf("sat_up%0d", i), dval(), exp_up_d[i]);
      check_eq($sformatf("at_max%0d", i), int'(bus.at_max), exp_up_mx[i]);
    end

    // Saturation downward
    for (int i = 0; i < 8; i++) begin
      press(1'b0, 1'b1, 1'b0);
      check_eq($sformatf("sat_dn%0d", i), dval(), exp_dn_d[i]);
      check_eq($sformatf("at_min%0d", i), int'(bus.at_min), exp_dn_mn[i]);
    end
    check_eq("no_wrap", int'(range_bad), 0);

    // Glitch rejection: 3 high, 1 low, 3 high never reaches 4 in a row
    bus.btn_up = 1'b1; tick(3);
    bus.btn_up = 1'b0; tick(1);
    bus.btn_up = 1'b1; tick(3);
    bus.btn_up = 1'b0; tick(12);
    check_eq("glitch_reject", dval(), -4);

    // Bounce train then a solid hold: exactly one increment
    bus.btn_up = 1'b1; tick(2);
    bus.btn_up = 1'b0; tick(1);
    bus.btn_up = 1'b1; tick(1);
    bus.btn_up = 1'b0; tick(1);
    bus.btn_up = 1'b1; tick(8);
    bus.btn_up = 1'b0; tick(12);
    check_eq("bounce_one_inc", dval(), -3);

    // Up and down on the same edge cancel
    press(1'b1, 1'b1, 1'b0);
    check_eq("up_dn_cancel", dval(), -3);

    // Clear beats up on the same edge
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_eq("pre_clr_up", dval(), 2);
    press(1'b1, 1'b0, 1'b1);
    check_eq("clr_beats_up", dval(), 0);

    // Async reset mid-debounce, then re-filter of the still-held button
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_data", dval(), 3);
    check_eq("pre_rst_at_max", int'(bus.at_max), 1);
    bus.btn_dn = 1'b1;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_data", dval(), 0);
    check_eq("async_rst_at_max", int'(bus.at_max), 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check_eq("post_rst_edge6", dval(), 0);
    tick(1);
    check_eq("post_rst_edge7", dval(), -1);
    check_eq("post_rst_at_min", int'(bus.at_min), 0);
    bus.btn_dn = 1'b0;
    tick(12);
    check_eq("post_rst_hold", dval(), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
